// File: rtl/cpu_bus_responder.sv
// CPU bus responder: 2 KB mirrored work RAM, PRG ROM window, open-bus reads,
// and a 256-byte sprite DMA engine that halts the CPU while it copies a page
// into sprite memory (OAM).
module cpu_bus_responder #(
  parameter int unsigned RAM_AW  = 11,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic        RW,
  input  logic [7:0]  Data_in,
  output logic [7:0]  Data_bus,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        rdy,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RD,
    ST_WR
  } state_e;

  state_e     state_q;
  logic [7:0] src_page_q;
  logic [7:0] cnt_q;
  logic [7:0] dma_byte_q;
  logic [7:0] data_bus_q;
  logic [7:0] oam_addr_q;
  logic [7:0] oam_data_q;
  logic       oam_we_q;
  logic       rdy_q;

  // Work RAM: contents survive reset.
  logic [7:0] ram_q [0:(1 << RAM_AW) - 1];

  logic [15:0] ea;
  logic        ram_sel;
  logic        rom_sel;
  logic        mapped;
  logic [7:0]  mapped_byte;
  logic        cpu_active;
  logic        dma_trig;
  logic        ram_we;
  logic [7:0]  data_bus_d;
  logic [7:0]  dma_byte_d;

  // Effective address: the CPU owns the bus in IDLE, the DMA engine otherwise.
  always_comb begin
    ea = Addr_bus;
    if (state_q != ST_IDLE) begin
      ea = {src_page_q, cnt_q};
    end
  end

  // Address decode and read-data select; unmapped space yields no byte.
  always_comb begin
    ram_sel     = (ea[15:13] == 3'b000);
    rom_sel     = ea[15];
    mapped      = ram_sel | rom_sel;
    mapped_byte = 8'h00;
    if (ram_sel) begin
      mapped_byte = ram_q[ea[RAM_AW-1:0]];
    end else if (rom_sel) begin
      mapped_byte = rom_data;
    end
  end

  // CPU access qualification and next values for the held bytes (open bus
  // keeps the previous value for both the CPU read path and the DMA byte).
  always_comb begin
    cpu_active = rst && (state_q == ST_IDLE);
    dma_trig   = cpu_active && !RW && (Addr_bus == DMA_REG);
    ram_we     = cpu_active && !RW && ram_sel && !dma_trig;
    data_bus_d = data_bus_q;
    if (cpu_active && RW && mapped) begin
      data_bus_d = mapped_byte;
    end
    dma_byte_d = dma_byte_q;
    if ((state_q == ST_RD) && mapped) begin
      dma_byte_d = mapped_byte;
    end
  end

  // RAM write port; CPU writes only, never during DMA or reset.
  always_ff @(posedge clk_ph1) begin
    if (ram_we) begin
      ram_q[ea[RAM_AW-1:0]] <= Data_in;
    end
  end

  // DMA state machine with registered CPU read data, rdy and OAM strobe.
  // The OAM strobe is set on the RD->WR edge so it is high exactly during WR.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b1;
      oam_we_q   <= 1'b0;
      oam_addr_q <= '0;
      oam_data_q <= '0;
      data_bus_q <= '0;
      cnt_q      <= '0;
      src_page_q <= '0;
      dma_byte_q <= '0;
    end else begin
      oam_we_q   <= 1'b0;
      data_bus_q <= data_bus_d;
      case (state_q)
        ST_IDLE: begin
          if (dma_trig) begin
            src_page_q <= Data_in;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            state_q    <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          state_q <= ST_RD;
        end
        ST_RD: begin
          dma_byte_q <= dma_byte_d;
          oam_we_q   <= 1'b1;
          oam_addr_q <= cnt_q;
          oam_data_q <= dma_byte_d;
          state_q    <= ST_WR;
        end
        ST_WR: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = ea[14:0];
  assign Data_bus = data_bus_q;
  assign rdy      = rdy_q;
  assign oam_addr = oam_addr_q;
  assign oam_data = oam_data_q;
  assign oam_we   = oam_we_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder: RAM mirroring, ROM window,
// open bus, sprite DMA (RAM/ROM/open-bus sources), DMA bus isolation and
// reset during DMA. Read and OAM expectations go through scoreboard queues.
module tb_cpu_bus_responder;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] Addr_bus;
  logic        RW;
  logic [7:0]  Data_in;
  logic [7:0]  Data_bus;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rdy;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rd_q[$];
  logic [15:0] oam_q[$];
  logic [7:0]  last_db;

  always #5 clk_ph1 = ~clk_ph1;

  // ROM model: each byte equals the low address byte.
  assign rom_data = rom_addr[7:0];

  cpu_bus_responder #(
    .RAM_AW (11),
    .DMA_REG(16'h4014)
  ) dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .Addr_bus(Addr_bus),
    .RW      (RW),
    .Data_in (Data_in),
    .Data_bus(Data_bus),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rdy     (rdy),
    .oam_addr(oam_addr),
    .oam_data(oam_data),
    .oam_we  (oam_we)
  );

  task automatic step();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    Addr_bus = a;
    RW       = 1'b0;
    Data_in  = d;
    step();
    RW       = 1'b1;
    Addr_bus = 16'h5000;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp);
    Addr_bus = a;
    RW       = 1'b1;
    rd_q.push_back(exp);
    step();
    Addr_bus = 16'h5000;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b0;
    step();
    step();
    tests++; if (Data_bus !== 8'h00) begin fails++; $display("FAIL reset_data_bus: got %h expected 00", Data_bus); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    tests++; if (oam_we !== 1'b0) begin fails++; $display("FAIL reset_oam_we: got %b expected 0", oam_we); end
    tests++; if (oam_addr !== 8'h00) begin fails++; $display("FAIL reset_oam_addr: got %h expected 00", oam_addr); end
    tests++; if (oam_data !== 8'h00) begin fails++; $display("FAIL reset_oam_data: got %h expected 00", oam_data); end
    rst = 1'b1;
    cpu_write(16'h0006, 8'h11);
    // Bus accesses while in reset must be ignored (RAM write and DMA trigger).
    rst = 1'b0;
    cpu_write(16'h0006, 8'hEE);
    cpu_write(16'h4014, 8'h02);
    rst = 1'b1;
    step();
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL reset_no_trigger: rdy got %b expected 1", rdy); end
    cpu_read(16'h0006, 8'h11);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL reset_ignores_write: got %h expected %h", Data_bus, e); end
    last_db = e;
  endtask

  task automatic test_mirror();
    logic [7:0] e;
    cpu_write(16'h0005, 8'h5A);
    cpu_read(16'h1805, 8'h5A);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL mirror_1805: got %h expected %h", Data_bus, e); end
    cpu_write(16'h1FFF, 8'h9E);
    cpu_read(16'h07FF, 8'h9E);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL mirror_1fff: got %h expected %h", Data_bus, e); end
    last_db = e;
  endtask

  task automatic test_rom();
    logic [7:0] e;
    cpu_write(16'h0000, 8'h3C);
    Addr_bus = 16'hFFFC;
    RW       = 1'b1;
    rd_q.push_back(8'hFC);
    #1;
    tests++; if (rom_addr !== 15'h7FFC) begin fails++; $display("FAIL rom_addr: got %h expected 7ffc", rom_addr); end
    step();
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL rom_read_fffc: got %h expected %h", Data_bus, e); end
    cpu_write(16'h8000, 8'h11);
    tests++; if (Data_bus !== 8'hFC) begin fails++; $display("FAIL rom_write_data_bus: got %h expected fc", Data_bus); end
    cpu_read(16'h0000, 8'h3C);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL rom_write_ignored: got %h expected %h", Data_bus, e); end
    cpu_read(16'h8123, 8'h23);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL rom_read_8123: got %h expected %h", Data_bus, e); end
    last_db = e;
  endtask

  task automatic test_open_bus();
    logic [15:0] addrs [4] = '{16'h5000, 16'h2000, 16'h7FFF, 16'h4014};
    logic [7:0] e;
    cpu_write(16'h0010, 8'h33);
    cpu_read(16'h0010, 8'h33);
    e = rd_q.pop_front();
    tests++; if (Data_bus !== e) begin fails++; $display("FAIL open_setup: got %h expected %h", Data_bus, e); end
    for (int k = 0; k < 4; k++) begin
      cpu_read(addrs[k], 8'h33);
      e = rd_q.pop_front();
      tests++; if (Data_bus !== e) begin fails++; $display("FAIL open_read_%h: got %h expected %h", addrs[k], Data_bus, e); end
    end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL open_read_dma_reg_rdy: got %b expected 1", rdy); end
    last_db = 8'h33;
  endtask

  task automatic test_dma();
    int halt;
    int pulses;
    bit done;
    logic [15:0] e;
    for (int i = 0; i < 256; i++) begin
      cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hA5);
    end
    for (int i = 0; i < 256; i++) begin
      oam_q.push_back({8'(i), 8'(i) ^ 8'hA5});
    end
    cpu_write(16'h4014, 8'h02);
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL dma_rdy_drop: got %b expected 0", rdy); end
    // Halt window counts the trigger cycle plus every sampled cycle with rdy low.
    halt = 1; pulses = 0; done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (rdy === 1'b1) begin
        done = 1;
      end else begin
        halt++;
        if (oam_we === 1'b1) begin
          pulses++;
          e = (oam_q.size() != 0) ? oam_q.pop_front() : 16'hxxxx;
          tests++; if ({oam_addr, oam_data} !== e) begin fails++; $display("FAIL dma_pulse_%0d: got %h expected %h", pulses, {oam_addr, oam_data}, e); end
        end
        step();
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL dma_timeout: got busy expected rdy within 1000 cycles"); end
    tests++; if (halt !== 514) begin fails++; $display("FAIL dma_halt_cycles: got %0d expected 514", halt); end
    tests++; if (pulses !== 256) begin fails++; $display("FAIL dma_pulses: got %0d expected 256", pulses); end
    tests++; if (oam_we !== 1'b0) begin fails++; $display("FAIL dma_we_after: got %b expected 0", oam_we); end
    tests++; if (Data_bus !== last_db) begin fails++; $display("FAIL dma_data_bus: got %h expected %h", Data_bus, last_db); end
    oam_q.delete();
  endtask

  task automatic test_dma_ignore();
    int halt;
    int pulses;
    bit done;
    logic [15:0] e;
    logic [7:0] r;
    for (int i = 0; i < 256; i++) begin
      oam_q.push_back({8'(i), 8'(i) ^ 8'hA5});
    end
    cpu_write(16'h4014, 8'h02);
    halt = 1; pulses = 0; done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      if (rdy === 1'b1) begin
        done = 1;
      end else begin
        halt++;
        if (oam_we === 1'b1) begin
          pulses++;
          e = (oam_q.size() != 0) ? oam_q.pop_front() : 16'hxxxx;
          tests++; if ({oam_addr, oam_data} !== e) begin fails++; $display("FAIL ign_pulse_%0d: got %h expected %h", pulses, {oam_addr, oam_data}, e); end
        end
        case (c)
          10: begin Addr_bus = 16'h0200; RW = 1'b0; Data_in = 8'h77; end
          11: begin Addr_bus = 16'h4014; RW = 1'b0; Data_in = 8'h03; end
          12: begin Addr_bus = 16'h8001; RW = 1'b1; end
          13: begin Addr_bus = 16'h5000; RW = 1'b1; end
          default: ;
        endcase
        step();
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL ign_timeout: got busy expected rdy within 1000 cycles"); end
    tests++; if (halt !== 514) begin fails++; $display("FAIL ign_halt_cycles: got %0d expected 514", halt); end
    tests++; if (pulses !== 256) begin fails++; $display("FAIL ign_pulses: got %0d expected 256", pulses); end
    tests++; if (Data_bus !== last_db) begin fails++; $display("FAIL ign_data_bus: got %h expected %h", Data_bus, last_db); end
    for (int c = 0; c < 4; c++) step();
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL ign_no_retrigger: rdy got %b expected 1", rdy); end
    cpu_read(16'h0200, 8'hA5);
    r = rd_q.pop_front();
    tests++; if (Data_bus !== r) begin fails++; $display("FAIL ign_ram_unchanged: got %h expected %h", Data_bus, r); end
    last_db = r;
    oam_q.delete();
  endtask

  task automatic test_dma_sources();
    // Pass 0: open-bus page repeats the last DMA byte (0xFF ^ 0xA5 = 0x5A).
    // Pass 1: ROM page 0x80 returns the low address byte.
    logic [7:0] pages [2] = '{8'h50, 8'h80};
    int halt;
    int pulses;
    bit done;
    logic [15:0] e;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        oam_q.push_back({8'(i), (p == 0) ? 8'h5A : 8'(i)});
      end
      cpu_write(16'h4014, pages[p]);
      halt = 1; pulses = 0; done = 0;
      for (int c = 0; c < 1000 && !done; c++) begin
        if (rdy === 1'b1) begin
          done = 1;
        end else begin
          halt++;
          if (oam_we === 1'b1) begin
            pulses++;
            e = (oam_q.size() != 0) ? oam_q.pop_front() : 16'hxxxx;
            tests++; if ({oam_addr, oam_data} !== e) begin fails++; $display("FAIL src%0d_pulse_%0d: got %h expected %h", p, pulses, {oam_addr, oam_data}, e); end
          end
          step();
        end
      end
      tests++; if (!done) begin fails++; $display("FAIL src%0d_timeout: got busy expected rdy within 1000 cycles", p); end
      tests++; if (halt !== 514) begin fails++; $display("FAIL src%0d_halt_cycles: got %0d expected 514", p, halt); end
      tests++; if (pulses !== 256) begin fails++; $display("FAIL src%0d_pulses: got %0d expected 256", p, pulses); end
      oam_q.delete();
    end
  endtask

  task automatic test_reset_mid_dma();
    int pulses;
    int late;
    logic [15:0] e;
    logic [7:0] r;
    for (int i = 0; i < 256; i++) begin
      oam_q.push_back({8'(i), 8'(i) ^ 8'hA5});
    end
    cpu_write(16'h4014, 8'h02);
    pulses = 0;
    for (int c = 0; c < 1000 && pulses < 40; c++) begin
      if (oam_we === 1'b1) begin
        pulses++;
        e = (oam_q.size() != 0) ? oam_q.pop_front() : 16'hxxxx;
        tests++; if ({oam_addr, oam_data} !== e) begin fails++; $display("FAIL rst_pulse_%0d: got %h expected %h", pulses, {oam_addr, oam_data}, e); end
      end
      if (pulses < 40) step();
    end
    tests++; if (pulses !== 40) begin fails++; $display("FAIL rst_reach_40: got %0d expected 40", pulses); end
    rst = 1'b0;
    step();
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL rst_mid_rdy: got %b expected 1", rdy); end
    tests++; if (oam_we !== 1'b0) begin fails++; $display("FAIL rst_mid_oam_we: got %b expected 0", oam_we); end
    tests++; if (oam_addr !== 8'h00) begin fails++; $display("FAIL rst_mid_oam_addr: got %h expected 00", oam_addr); end
    tests++; if (Data_bus !== 8'h00) begin fails++; $display("FAIL rst_mid_data_bus: got %h expected 00", Data_bus); end
    rst = 1'b1;
    late = 0;
    for (int c = 0; c < 600; c++) begin
      if (oam_we === 1'b1) late++;
      step();
    end
    tests++; if (late !== 0) begin fails++; $display("FAIL rst_no_more_pulses: got %0d expected 0", late); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL rst_rdy_stays: got %b expected 1", rdy); end
    oam_q.delete();
    cpu_read(16'h0005, 8'h5A);
    r = rd_q.pop_front();
    tests++; if (Data_bus !== r) begin fails++; $display("FAIL rst_ram_kept_0005: got %h expected %h", Data_bus, r); end
    cpu_read(16'h02FF, 8'h5A);
    r = rd_q.pop_front();
    tests++; if (Data_bus !== r) begin fails++; $display("FAIL rst_ram_kept_02ff: got %h expected %h", Data_bus, r); end
  endtask

  initial begin
    rst      = 1'b0;
    Addr_bus = 16'h5000;
    RW       = 1'b1;
    Data_in  = 8'h00;
    last_db  = 8'h00;
    test_reset();
    test_mirror();
    test_rom();
    test_open_bus();
    test_dma();
    test_dma_ignore();
    test_dma_sources();
    test_reset_mid_dma();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, meaning the internal work-RAM address width (2 KB).
REQ-002 SHALL have parameter DMA_REG, default 16'h4014, meaning the CPU address whose write starts sprite DMA.
REQ-003 SHALL have port clk_ph1, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port Addr_bus, input, 16, the CPU address.
REQ-006 SHALL have port RW, input, 1, where 1 = CPU read and 0 = CPU write.
REQ-007 SHALL have port Data_in, input, 8, the CPU write data.
REQ-008 SHALL have port Data_bus, output, 8, the registered read data returned to the CPU.
REQ-009 SHALL have port rom_addr, output, 15, the PRG ROM address.
REQ-010 SHALL have port rom_data, input, 8, the combinational PRG ROM data for rom_addr.
REQ-011 SHALL have port rdy, output, 1, the CPU run enable; 0 halts the CPU.
REQ-012 SHALL have port oam_addr, output, 8, the sprite memory write address.
REQ-013 SHALL have port oam_data, output, 8, the sprite memory write data.
REQ-014 SHALL have port oam_we, output, 1, the one-cycle sprite memory write strobe.

Function
REQ-015 SHALL decode the effective address EA; EA = Addr_bus when not in DMA, and EA = {src_page, cnt} during DMA.
REQ-016 SHALL map EA 0x0000-0x1FFF to RAM at index EA[RAM_AW-1:0], so the RAM is mirrored every 2 KB.
REQ-017 SHALL map EA 0x8000-0xFFFF to ROM, with rom_addr = EA[14:0] combinationally at all times.
REQ-018 SHALL treat all other EA as unmapped: writes are ignored and reads hold Data_bus at its previous value (open bus).
REQ-019 SHALL, on a CPU read (RW=1, not in DMA), register the selected byte into Data_bus at the edge, giving read latency 1 cycle.
REQ-020 SHALL, on a CPU write (RW=0, not in DMA) to RAM space, write Data_in into RAM at the edge and leave Data_bus unchanged.
REQ-021 SHALL ignore ROM-space writes.
REQ-022 SHALL run a DMA state machine with states IDLE, ALIGN, RD and WR.
REQ-023 SHALL, in IDLE, on RW=0 and Addr_bus=DMA_REG: capture src_page <= Data_in, set cnt <= 0, go to ALIGN, and drive rdy <= 0 at that edge.
REQ-024 SHALL, in ALIGN, go to RD after one cycle.
REQ-025 SHALL, in RD, read EA = {src_page, cnt} from RAM, ROM or open bus into an internal dma_byte, then go to WR.
REQ-026 SHALL, in WR, drive oam_we=1, oam_addr=cnt and oam_data=dma_byte for exactly this cycle, then cnt <= cnt+1.
REQ-027 SHALL, in WR with cnt=255, wrap cnt to 0, go to IDLE and drive rdy <= 1.
REQ-028 SHALL hold rdy=0 for exactly 514 cycles per DMA (1 ALIGN + 256 RD + 256 WR + the trigger edge), producing exactly 256 oam_we pulses with addresses 0..255 in order.
REQ-029 SHALL, while not in IDLE, ignore Addr_bus, RW and Data_in, including writes to DMA_REG (no retrigger), and leave Data_bus unchanged.
REQ-030 SHALL drive oam_we=0 in every state other than WR.
REQ-031 SHALL, for an open-bus DMA source, supply the last dma_byte (0x00 after reset) as the byte.
REQ-032 SHALL update all registered outputs only on the clk_ph1 rising edge.

Reset
REQ-033 SHALL, while rst=0 at an edge, set state=IDLE, rdy=1, oam_we=0, oam_addr=0, oam_data=0, Data_bus=0, cnt=0, src_page=0 and dma_byte=0.
REQ-034 SHALL, on reset mid-DMA, abort the DMA at that edge with no further oam_we pulses.
REQ-035 SHALL never clear RAM contents on reset.
REQ-036 SHALL ignore bus accesses during reset.

Verification
REQ-037 SHALL be verified by: write 0x5A to 0x0005, then read 0x1805 -> Data_bus = 0x5A one cycle after the read address (mirror).
REQ-038 SHALL be verified by: read 0xFFFC with rom_data model = addr[7:0] -> rom_addr = 0x7FFC and Data_bus = 0xFC next cycle; write 0x8000 -> no effect.
REQ-039 SHALL be verified by: Data_bus = 0x33, then read 0x5000 -> Data_bus stays 0x33.
REQ-040 SHALL be verified by: fill RAM 0x0200-0x02FF with i^0xA5, then write 0x02 to 0x4014 -> rdy low for 514 cycles and 256 oam_we pulses with oam_addr = i and oam_data = i^0xA5.
REQ-041 SHALL be verified by: during DMA, CPU writes 0x77 to 0x0200 and 0x03 to 0x4014 -> RAM unchanged, no retrigger, and the total pulse count stays 256.
REQ-042 SHALL be verified by: assert rst after 40 oam_we pulses -> next edge rdy=1 and oam_we=0, no more pulses, and a prior RAM byte is still readable.
